// File: rtl/convolution_processor_mac_engine.sv
// rtl/convolution_processor_mac_engine.sv - Linear convolution MAC engine: sequences X/Y reads, accumulates, writes Z terms
module convolution_processor_mac_engine #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int ACC_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W:0]   size_x_i,
    input  logic [ADDR_W:0]   size_y_i,
    output logic [ADDR_W-1:0] mem_x_addr_o,
    input  logic [DATA_W-1:0] mem_x_data_i,
    output logic [ADDR_W-1:0] mem_y_addr_o,
    input  logic [DATA_W-1:0] mem_y_data_i,
    output logic [ADDR_W:0]   mem_z_addr_o,
    output logic [ACC_W-1:0]  mem_z_data_o,
    output logic              mem_z_we_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_READ,
        S_MAC,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ONE_I = 1;
    localparam logic [ADDR_W:0]   ONE_S = 1;
    localparam logic [ADDR_W+1:0] TWO_K = 2;

    state_t state, state_next;

    logic [ADDR_W:0]          size_x;
    logic [ADDR_W:0]          size_y;
    logic [ADDR_W:0]          k;
    logic [ADDR_W-1:0]        i;
    logic [ACC_W-1:0]         acc;
    logic [ADDR_W:0]          z_addr_hold;
    logic [ACC_W-1:0]         z_data_hold;
    logic signed [ADDR_W+1:0] j;
    logic                     j_valid;
    logic                     i_last;
    logic                     k_last;
    logic                     size_zero;
    logic [2*DATA_W-1:0]      product;

    // j = k - i carries one extra sign bit so negative (out-of-range) indices are detectable
    assign j         = $signed({1'b0, k}) - $signed({2'b00, i});
    assign j_valid   = (j >= 0) && (j < $signed({1'b0, size_y}));
    assign i_last    = (({1'b0, i}) + ONE_S) == size_x;
    assign k_last    = (({1'b0, k}) + TWO_K) == (({1'b0, size_x}) + ({1'b0, size_y}));
    assign size_zero = (size_x == '0) || (size_y == '0);
    assign product   = mem_x_data_i * mem_y_data_i;

    // i and k only change at the end of MAC/READ/WRITE, so the addresses stay put through MAC
    assign mem_x_addr_o = i;
    assign mem_y_addr_o = j[ADDR_W-1:0];
    assign mem_z_we_o   = (state == S_WRITE);
    assign mem_z_addr_o = (state == S_WRITE) ? k : z_addr_hold;
    assign mem_z_data_o = (state == S_WRITE) ? acc : z_data_hold;
    assign busy_o       = (state != S_IDLE);
    assign done_o       = (state == S_DONE);

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start_i) state_next = S_INIT;
            S_INIT:  state_next = size_zero ? S_DONE : S_READ;
            S_READ: begin
                if (j_valid) begin
                    state_next = S_MAC;
                end else if (i_last) begin
                    state_next = S_WRITE;
                end
            end
            S_MAC:   state_next = i_last ? S_WRITE : S_READ;
            S_WRITE: state_next = k_last ? S_DONE : S_INIT;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Index counters, latched sizes, accumulator and the held Z output values
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            size_x      <= '0;
            size_y      <= '0;
            k           <= '0;
            i           <= '0;
            acc         <= '0;
            z_addr_hold <= '0;
            z_data_hold <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        size_x <= size_x_i;
                        size_y <= size_y_i;
                        k      <= '0;
                    end
                end
                S_INIT: begin
                    acc <= '0;
                    i   <= '0;
                end
                S_READ: begin
                    if (!j_valid && !i_last) begin
                        i <= i + ONE_I;
                    end
                end
                S_MAC: begin
                    acc <= acc + ACC_W'(product);
                    if (!i_last) begin
                        i <= i + ONE_I;
                    end
                end
                S_WRITE: begin
                    z_addr_hold <= k;
                    z_data_hold <= acc;
                    if (!k_last) begin
                        k <= k + ONE_S;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_convolution_processor_mac_engine.sv
// tb/tb_convolution_processor_mac_engine.sv - Directed self-checking bench for the convolution MAC engine
module tb_convolution_processor_mac_engine;

    logic        clk;
    logic        rst;
    logic        start;
    logic [5:0]  size_x;
    logic [5:0]  size_y;
    logic [4:0]  x_addr;
    logic [7:0]  x_data;
    logic [4:0]  y_addr;
    logic [7:0]  y_data;
    logic [5:0]  z_addr;
    logic [15:0] z_data;
    logic        z_we;
    logic        busy;
    logic        done;

    logic [7:0]  x_mem [32];
    logic [7:0]  y_mem [32];
    logic [15:0] z_mem [64];

    int          wr_n;
    int          wr_addr [128];
    int          wr_data [128];
    int          wr_cyc  [128];
    int          done_cnt;
    int          done_cyc;
    int          cyc;
    int          base;
    int          compared;
    int          mismatched;

    convolution_processor_mac_engine #(
        .DATA_W(8),
        .ADDR_W(5),
        .ACC_W (16)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .size_x_i    (size_x),
        .size_y_i    (size_y),
        .mem_x_addr_o(x_addr),
        .mem_x_data_i(x_data),
        .mem_y_addr_o(y_addr),
        .mem_y_data_i(y_data),
        .mem_z_addr_o(z_addr),
        .mem_z_data_o(z_data),
        .mem_z_we_o  (z_we),
        .busy_o      (busy),
        .done_o      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        x_data <= x_mem[x_addr];
        y_data <= y_mem[y_addr];
    end

    always @(negedge clk) begin
        if (z_we) begin
            if (wr_n < 128) begin
                wr_addr[wr_n] = int'(z_addr);
                wr_data[wr_n] = int'(z_data);
                wr_cyc[wr_n]  = cyc - base;
            end
            wr_n = wr_n + 1;
            z_mem[z_addr] = z_data;
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc - base;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared = compared + 1;
        assert (obs === exp) else begin
            mismatched = mismatched + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wr_n     = 0;
        done_cnt = 0;
        done_cyc = -1;
        for (int n = 0; n < 64; n++) z_mem[n] = 16'h0;
    endtask

    task automatic start_run(input logic [5:0] sx, input logic [5:0] sy);
        @(negedge clk);
        size_x = sx;
        size_y = sy;
        start  = 1'b1;
        @(posedge clk);
        #1;
        base  = cyc - 1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 5000 && !seen; n++) begin
            @(negedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic check_basic(input string tag);
        check({tag, "_nwr"}, 32'(wr_n), 32'd4);
        check({tag, "_a0"}, 32'(wr_addr[0]), 32'd0);
        check({tag, "_d0"}, 32'(wr_data[0]), 32'd1);
        check({tag, "_a1"}, 32'(wr_addr[1]), 32'd1);
        check({tag, "_d1"}, 32'(wr_data[1]), 32'd3);
        check({tag, "_a2"}, 32'(wr_addr[2]), 32'd2);
        check({tag, "_d2"}, 32'(wr_data[2]), 32'd5);
        check({tag, "_a3"}, 32'(wr_addr[3]), 32'd3);
        check({tag, "_d3"}, 32'(wr_data[3]), 32'd3);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        cyc        = 0;
        base       = 0;
        rst        = 1'b1;
        start      = 1'b0;
        size_x     = 6'd0;
        size_y     = 6'd0;
        for (int n = 0; n < 32; n++) begin
            x_mem[n] = 8'd0;
            y_mem[n] = 8'd0;
        end
        clear_log();

        // reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_we", 32'(z_we), 32'd0);
        check("rst_zaddr", 32'(z_addr), 32'd0);
        check("rst_zdata", 32'(z_data), 32'd0);
        check("rst_xaddr", 32'(x_addr), 32'd0);
        check("rst_yaddr", 32'(y_addr), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // minimal case: 5*7 written at cycle 4, done at cycle 5, busy cycles 1..5
        x_mem[0] = 8'd5;
        y_mem[0] = 8'd7;
        clear_log();
        start_run(6'd1, 6'd1);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("min_busy_c%0d", c), 32'(busy), (c <= 5) ? 32'd1 : 32'd0);
        end
        check("min_nwr", 32'(wr_n), 32'd1);
        check("min_addr", 32'(wr_addr[0]), 32'd0);
        check("min_data", 32'(wr_data[0]), 32'd35);
        check("min_wr_cyc", 32'(wr_cyc[0]), 32'd4);
        check("min_done_cyc", 32'(done_cyc), 32'd5);
        check("min_done_cnt", 32'(done_cnt), 32'd1);

        // basic convolution X=[1,2,3] Y=[1,1] -> Z=[1,3,5,3]
        x_mem[0] = 8'd1; x_mem[1] = 8'd2; x_mem[2] = 8'd3;
        y_mem[0] = 8'd1; y_mem[1] = 8'd1;
        clear_log();
        start_run(6'd3, 6'd2);
        wait_done("basic_done_seen");
        check("basic_busy_at_done", 32'(busy), 32'd1);
        @(negedge clk);
        #1;
        check("basic_busy_after", 32'(busy), 32'd0);
        check("basic_done_after", 32'(done), 32'd0);
        check("basic_done_cnt", 32'(done_cnt), 32'd1);
        check_basic("basic");
        check("basic_hold_zaddr", 32'(z_addr), 32'd3);
        check("basic_hold_zdata", 32'(z_data), 32'd3);
        check("basic_hold_we", 32'(z_we), 32'd0);

        // zero size: no writes, done at cycle 2
        clear_log();
        start_run(6'd0, 6'd4);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("zero_done_c%0d", c), 32'(done), (c == 2) ? 32'd1 : 32'd0);
            check($sformatf("zero_busy_c%0d", c), 32'(busy), (c <= 2) ? 32'd1 : 32'd0);
        end
        check("zero_nwr", 32'(wr_n), 32'd0);

        // accumulator wrap with full-size operands
        for (int n = 0; n < 32; n++) begin
            x_mem[n] = 8'd255;
            y_mem[n] = 8'd255;
        end
        clear_log();
        start_run(6'd32, 6'd32);
        wait_done("wrap_done_seen");
        @(negedge clk);
        check("wrap_nwr", 32'(wr_n), 32'd63);
        check("wrap_z0", 32'(z_mem[0]), 32'd65025);
        check("wrap_z31", 32'(z_mem[31]), 32'd49184);
        check("wrap_z62", 32'(z_mem[62]), 32'd65025);
        check("wrap_last_addr", 32'(wr_addr[62]), 32'd62);
        check("wrap_done_cnt", 32'(done_cnt), 32'd1);

        // start and size changes while busy are ignored
        for (int n = 0; n < 32; n++) begin
            x_mem[n] = 8'd0;
            y_mem[n] = 8'd0;
        end
        x_mem[0] = 8'd1; x_mem[1] = 8'd2; x_mem[2] = 8'd3;
        y_mem[0] = 8'd1; y_mem[1] = 8'd1;
        clear_log();
        start_run(6'd3, 6'd2);
        repeat (3) @(negedge clk);
        start  = 1'b1;
        size_x = 6'd1;
        size_y = 6'd1;
        @(negedge clk);
        start  = 1'b0;
        size_x = 6'd5;
        size_y = 6'd5;
        wait_done("busy_start_done_seen");
        @(negedge clk);
        check_basic("busy_start");
        check("busy_start_done_cnt", 32'(done_cnt), 32'd1);

        // reset during MAC of k=1 (cycle 9): immediate abort, no further writes
        clear_log();
        start_run(6'd3, 6'd2);
        repeat (9) @(negedge clk);
        check("abort_pre_busy", 32'(busy), 32'd1);
        check("abort_pre_xaddr", 32'(x_addr), 32'd0);
        check("abort_pre_yaddr", 32'(y_addr), 32'd1);
        check("abort_pre_nwr", 32'(wr_n), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_we", 32'(z_we), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_zaddr", 32'(z_addr), 32'd0);
        check("abort_zdata", 32'(z_data), 32'd0);
        repeat (3) @(negedge clk);
        check("abort_nwr", 32'(wr_n), 32'd1);
        check("abort_done_cnt", 32'(done_cnt), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // fresh run after the abort
        clear_log();
        start_run(6'd3, 6'd2);
        wait_done("post_rst_done_seen");
        @(negedge clk);
        check_basic("post_rst");
        check("post_rst_done_cnt", 32'(done_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/convolution_processor_mac_engine.md
Name: convolution_processor_mac_engine

Overview:
- Datapath and control engine of the convolution processor.
- Computes the full linear convolution Z[k] = sum over i of X[i]*Y[k-i] for k = 0..size_x+size_y-2.
- Reads the X and Y operand memories through synchronous read ports and writes each finished Z term into the result memory.
- Sits between the host-facing register/start logic (upstream) and the Z memory and its readback path (downstream).

Parameters:
- DATA_W, 8: width of X and Y samples (unsigned).
- ADDR_W, 5: X/Y memory address width; maximum size is 2^ADDR_W.
- ACC_W, 16: accumulator and Z sample width; results wrap modulo 2^ACC_W.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  start request, sampled in IDLE only.
- size_x_i  in  ADDR_W+1  number of X samples (0..2^ADDR_W).
- size_y_i  in  ADDR_W+1  number of Y samples (0..2^ADDR_W).
- mem_x_addr_o  out  ADDR_W  X memory read address.
- mem_x_data_i  in  DATA_W  X read data, valid one cycle after the address.
- mem_y_addr_o  out  ADDR_W  Y memory read address.
- mem_y_data_i  in  DATA_W  Y read data, valid one cycle after the address.
- mem_z_addr_o  out  ADDR_W+1  Z write address (k).
- mem_z_data_o  out  ACC_W  Z write data (accumulator).
- mem_z_we_o  out  1  Z write enable, one-cycle pulse per term.
- busy_o  out  1  high whenever the FSM is not in IDLE.
- done_o  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, rst_i=1):
  - FSM goes to IDLE.
  - All outputs are 0; i, j, k and the accumulator are cleared.
  - Reset mid-operation aborts immediately with no further Z write. Partially written Z contents are left as they are.
- IDLE:
  - If start_i=1, latch size_x_i and size_y_i into internal registers, set k=0, and go to INIT.
  - start_i is ignored in every other state.
- INIT:
  - If either latched size is 0, go to DONE.
  - Otherwise clear acc, set i=0, go to READ.
- READ:
  - Compute j = k - i as a signed value.
  - If 0 <= j < size_y: drive mem_x_addr_o=i and mem_y_addr_o=j[ADDR_W-1:0], then go to MAC.
  - Otherwise (term invalid) perform no read:
    - if i = size_x-1, go to WRITE;
    - else set i=i+1 and stay in READ.
- MAC:
  - Addresses are held from READ.
  - acc <= acc + zero-extend(mem_x_data_i * mem_y_data_i), truncated to ACC_W. The product is 2*DATA_W bits unsigned.
  - If i = size_x-1, go to WRITE; else set i=i+1 and go to READ.
- WRITE:
  - mem_z_we_o=1, mem_z_addr_o=k, mem_z_data_o=acc for exactly this cycle.
  - If k = size_x+size_y-2, go to DONE; else set k=k+1 and go to INIT.
- DONE:
  - done_o=1 for one cycle, then go to IDLE.
- Output timing:
  - busy_o=1 in INIT, READ, MAC, WRITE and DONE; busy_o=0 in IDLE.
  - mem_z_we_o is 0 outside WRITE.
  - mem_z_data_o and mem_z_addr_o keep their last values outside WRITE.
- Timing and latency:
  - Each valid term costs 2 cycles; each invalid index costs 1 cycle.
  - Each output term adds 2 cycles of overhead (INIT + WRITE).
  - With size_x=size_y=1, start sampled at cycle 0 gives: INIT c1, READ c2, MAC c3, WRITE c4, DONE c5.
- Boundary conditions:
  - size_x = 2^ADDR_W is legal; index i fits in ADDR_W bits.
  - The Z address reaches at most 2^(ADDR_W+1)-2.
  - start_i held high continuously restarts one cycle after DONE, i.e. from IDLE.
  - size inputs that change while busy have no effect.

Test Plan:
- Basic convolution: X=[1,2,3], Y=[1,1], start -> four writes in the order Z[0]=1, Z[1]=3, Z[2]=5, Z[3]=3; exactly one done_o pulse; busy_o falls the cycle after done_o.
- Minimal case: X=[5], Y=[7], start at cycle 0 -> mem_z_we_o at cycle 4 with addr 0 and data 35; done_o at cycle 5; busy_o high cycles 1–5.
- Accumulator wrap: sizes 32/32, all samples 255 -> Z[31] = 32*65025 mod 65536 = 49184; Z[0] = 65025; Z[62] = 65025; 63 writes total.
- Zero size: size_x=0, size_y=4, start at cycle 0 -> no mem_z_we_o; done_o at cycle 2.
- start_i pulsed mid-run with different sizes -> ignored; results match the originally latched sizes.
- rst_i asserted during MAC of the X=[1,2,3] run -> outputs 0 asynchronously, no further writes; a fresh start afterwards produces correct results.
